// File: rtl/uart_frame_loader_if.sv
// Bundle of the loader's receive, clue-RAM, load-report and reply signals.
// master: the loader itself; slave: the surrounding uart_rx/RAM/solver/uart_tx side.
interface uart_frame_loader_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic                  load_valid;
  logic [7:0]            rows;
  logic [7:0]            cols;
  logic [7:0]            clue_len;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_data;
  logic [7:0]            err_count;

  modport master (
    input  rx_valid, rx_data, tx_ready,
    output mem_we, mem_addr, mem_data, load_valid, rows, cols, clue_len,
           tx_valid, tx_data, err_count
  );

  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  mem_we, mem_addr, mem_data, load_valid, rows, cols, clue_len,
           tx_valid, tx_data, err_count
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Frame parser: SYNC, ROWS, COLS, LEN, LEN clue bytes, checksum.
// Streams clues into the clue RAM, reports good frames, replies ACK/NAK.
module uart_frame_loader #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_DIM        = 16,
  parameter int         ADDR_WIDTH     = 8,
  parameter int         TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_frame_loader_if.master bus
);

  localparam int         TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);

  typedef enum logic [2:0] {
    IDLE, GET_ROWS, GET_COLS, GET_LEN, PAYLOAD, CHECK, REPLY
  } state_t;

  state_t state_q, state_d;

  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_data_q, mem_data_d;
  logic                  load_valid_q, load_valid_d;
  logic [7:0]            rows_q, rows_d, cols_q, cols_d, len_q, len_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic [7:0]            err_q, err_d;
  logic [7:0]            rows_sh_q, rows_sh_d, cols_sh_q, cols_sh_d, len_sh_q, len_sh_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            idx_q, idx_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic rxv, in_frame, tmo_hit, hdr_ok, last_payload;
  logic [7:0] err_inc;

  assign rxv          = bus.rx_valid;
  assign in_frame     = (state_q != IDLE) && (state_q != REPLY);
  assign tmo_hit      = in_frame && !rxv && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign hdr_ok       = (rows_sh_q != 8'd0) && (rows_sh_q <= MAX_DIM_B) &&
                        (cols_sh_q != 8'd0) && (cols_sh_q <= MAX_DIM_B);
  assign last_payload = (idx_q == len_sh_q - 8'd1);
  assign err_inc      = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: frame sequencing plus the inter-byte timeout escape
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (rxv && bus.rx_data == SYNC_BYTE) state_d = GET_ROWS;
        GET_ROWS: if (rxv) state_d = GET_COLS;
        GET_COLS: if (rxv) state_d = GET_LEN;
        GET_LEN:  if (rxv) state_d = (bus.rx_data == 8'd0) ? CHECK : PAYLOAD;
        PAYLOAD:  if (rxv && last_payload) state_d = CHECK;
        CHECK:    if (rxv) state_d = REPLY;
        REPLY:    if (tx_valid_q && bus.tx_ready) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values: shadows, checksum, RAM writes, reply, counters
  always_comb begin
    mem_we_d     = 1'b0;
    load_valid_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    rows_d       = rows_q;
    cols_d       = cols_q;
    len_d        = len_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    err_d        = err_q;
    rows_sh_d    = rows_sh_q;
    cols_sh_d    = cols_sh_q;
    len_sh_d     = len_sh_q;
    sum_d        = sum_q;
    idx_d        = idx_q;
    tmo_d        = (in_frame && !rxv && !tmo_hit) ? tmo_q + 1'b1 : '0;

    case (state_q)
      IDLE: if (rxv && bus.rx_data == SYNC_BYTE) begin
        sum_d = '0;
        idx_d = '0;
      end
      GET_ROWS: if (rxv) begin
        rows_sh_d = bus.rx_data;
        sum_d     = sum_q + bus.rx_data;
      end
      GET_COLS: if (rxv) begin
        cols_sh_d = bus.rx_data;
        sum_d     = sum_q + bus.rx_data;
      end
      GET_LEN: if (rxv) begin
        len_sh_d = bus.rx_data;
        sum_d    = sum_q + bus.rx_data;
        idx_d    = '0;
      end
      PAYLOAD: if (rxv) begin
        sum_d = sum_q + bus.rx_data;
        idx_d = idx_q + 8'd1;
        if (hdr_ok) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ADDR_WIDTH'(idx_q);
          mem_data_d = bus.rx_data;
        end
      end
      CHECK: if (rxv) begin
        tx_valid_d = 1'b1;
        if (hdr_ok && bus.rx_data == sum_q) begin
          rows_d       = rows_sh_q;
          cols_d       = cols_sh_q;
          len_d        = len_sh_q;
          load_valid_d = 1'b1;
          tx_data_d    = ACK_BYTE;
        end else begin
          tx_data_d = NAK_BYTE;
          err_d     = err_inc;
        end
      end
      REPLY: if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
      default: ;
    endcase

    if (tmo_hit) err_d = err_inc;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      load_valid_q <= 1'b0;
      rows_q       <= '0;
      cols_q       <= '0;
      len_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      err_q        <= '0;
      rows_sh_q    <= '0;
      cols_sh_q    <= '0;
      len_sh_q     <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      load_valid_q <= load_valid_d;
      rows_q       <= rows_d;
      cols_q       <= cols_d;
      len_q        <= len_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      err_q        <= err_d;
      rows_sh_q    <= rows_sh_d;
      cols_sh_q    <= cols_sh_d;
      len_sh_q     <= len_sh_d;
      sum_q        <= sum_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.load_valid = load_valid_q;
  assign bus.rows       = rows_q;
  assign bus.cols       = cols_q;
  assign bus.clue_len   = len_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.err_count  = err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Bench for uart_frame_loader: fixed frame table, corner sequences, random frames.
module tb_uart_frame_loader;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_frame_loader_if #(.ADDR_WIDTH(8)) bus ();

  uart_frame_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               n;
    logic [11:0][7:0] b;     // byte i of the frame lives at b[n-1-i]
    bit               ack;
    int               nwr;
    logic [7:0]       rows, cols, len;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int exp_err = 0;
  int exp_rows = 0, exp_cols = 0, exp_len = 0;
  bit rnd_gaps = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each RAM write must carry the byte received one cycle earlier
  logic       prev_rxv = 1'b0;
  logic [7:0] prev_rxd = '0;
  int wr_addr[$];
  int wr_data[$];
  int lv_cnt = 0;
  bit tx_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      chk("wr_latency", {prev_rxv, bus.mem_data}, {1'b1, prev_rxd});
      wr_addr.push_back(int'(bus.mem_addr));
      wr_data.push_back(int'(bus.mem_data));
    end
    if (bus.load_valid) lv_cnt++;
    if (bus.tx_valid) tx_seen = 1'b1;
    prev_rxv = bus.rx_valid;
    prev_rxd = bus.rx_data;
  end

  function automatic logic [7:0] byte_at(input vec_t v, input int i);
    return v.b[v.n-1-i];
  endfunction

  function automatic vec_t mk(input int n, input logic [95:0] bytes, input bit ack,
                              input int nwr, input logic [7:0] r, c, l);
    vec_t v;
    v.n = n; v.b = bytes; v.ack = ack; v.nwr = nwr;
    v.rows = r; v.cols = c; v.len = l;
    return v;
  endfunction

  // Reference: decide the frame's fate directly from its bytes
  function automatic vec_t model(input vec_t v);
    int sum;
    bit hdr;
    v.rows = byte_at(v, 1);
    v.cols = byte_at(v, 2);
    v.len  = byte_at(v, 3);
    sum = 0;
    for (int i = 1; i < v.n - 1; i++) sum += int'(byte_at(v, i));
    hdr = (v.rows >= 1 && v.rows <= 16 && v.cols >= 1 && v.cols <= 16);
    v.ack = hdr && ((sum % 256) == int'(byte_at(v, v.n - 1)));
    v.nwr = hdr ? int'(v.len) : 0;
    return v;
  endfunction

  function automatic vec_t rand_frame();
    vec_t v;
    int len, sum;
    len = $urandom_range(0, 6);
    v.n = 5 + len;
    v.b = '0;
    v.b[v.n-1] = 8'hA5;
    v.b[v.n-2] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 18)) : 8'($urandom_range(1, 16));
    v.b[v.n-3] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 18)) : 8'($urandom_range(1, 16));
    v.b[v.n-4] = 8'(len);
    for (int j = 0; j < len; j++) v.b[v.n-5-j] = 8'($urandom_range(0, 255));
    sum = 0;
    for (int i = 1; i < v.n - 1; i++) sum += int'(v.b[v.n-1-i]);
    if ($urandom_range(0, 3) == 0) sum += 1;
    v.b[0] = 8'(sum % 256);
    return model(v);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    idle(1);
    bus.rx_valid = 1'b0;
    idle(gap);
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    lv_cnt  = 0;
    tx_seen = 1'b0;
  endtask

  task automatic wait_tx();
    int w;
    w = 0;
    while (!bus.tx_valid && w < 10) begin
      idle(1);
      w++;
    end
    chk("tx_valid_rise", bus.tx_valid, 1);
  endtask

  task automatic check_result(input vec_t v);
    if (v.ack) begin
      exp_rows = v.rows; exp_cols = v.cols; exp_len = v.len;
    end else if (exp_err < 255) begin
      exp_err++;
    end
    chk("load_pulses", lv_cnt, v.ack ? 1 : 0);
    chk("rows", bus.rows, exp_rows);
    chk("cols", bus.cols, exp_cols);
    chk("clue_len", bus.clue_len, exp_len);
    chk("err_count", bus.err_count, exp_err);
    chk("write_count", wr_addr.size(), v.nwr);
    for (int j = 0; j < wr_addr.size() && j < v.nwr; j++) begin
      chk("write_addr", wr_addr[j], j);
      chk("write_data", wr_data[j], int'(byte_at(v, 4 + j)));
    end
  endtask

  task automatic run_frame(input vec_t v);
    int hold;
    logic [7:0] er;
    clear_mon();
    for (int i = 0; i < v.n; i++)
      send_byte(byte_at(v, i), (rnd_gaps && i != v.n - 1) ? $urandom_range(0, 3) : 0);
    wait_tx();
    er = v.ack ? 8'h06 : 8'h15;
    chk("tx_data", bus.tx_data, er);
    hold = rnd_gaps ? $urandom_range(0, 5) : 2;
    for (int k = 0; k < hold; k++) begin
      idle(1);
      chk("tx_hold", {bus.tx_valid, bus.tx_data}, {1'b1, er});
    end
    bus.tx_ready = 1'b1;
    idle(1);
    bus.tx_ready = 1'b0;
    chk("tx_drop", bus.tx_valid, 0);
    check_result(v);
  endtask

  vec_t tbl[6];
  vec_t v;
  logic [7:0] g;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;

    tbl[0] = mk(7, {8'hA5, 8'h03, 8'h04, 8'h02, 8'h11, 8'h22, 8'h3C}, 1'b1, 2, 8'd3, 8'd4, 8'd2);
    tbl[1] = mk(7, {8'hA5, 8'h03, 8'h04, 8'h02, 8'h11, 8'h22, 8'h3D}, 1'b0, 2, 8'd3, 8'd4, 8'd2);
    tbl[2] = mk(6, {8'hA5, 8'h00, 8'h04, 8'h01, 8'h55, 8'h5A}, 1'b0, 0, 8'd0, 8'd4, 8'd1);
    tbl[3] = mk(5, {8'hA5, 8'h01, 8'h01, 8'h00, 8'h02}, 1'b1, 0, 8'd1, 8'd1, 8'd0);
    tbl[4] = mk(6, {8'hA5, 8'h10, 8'h10, 8'h01, 8'h07, 8'h28}, 1'b1, 1, 8'd16, 8'd16, 8'd1);
    tbl[5] = mk(5, {8'hA5, 8'h11, 8'h01, 8'h00, 8'h12}, 1'b0, 0, 8'd17, 8'd1, 8'd0);

    idle(3);
    chk("reset_outputs",
        {bus.mem_we, bus.load_valid, bus.tx_valid, bus.mem_addr, bus.mem_data,
         bus.rows, bus.cols, bus.clue_len, bus.tx_data, bus.err_count}, 0);
    rst_n = 1'b1;
    idle(2);

    for (int t = 0; t < 6; t++) run_frame(tbl[t]);

    // Timeout: silence shorter than the limit is tolerated, longer aborts silently
    clear_mon();
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    idle(30);
    chk("no_early_timeout", bus.err_count, exp_err);
    idle(20);
    exp_err++;
    chk("timeout_err", bus.err_count, exp_err);
    chk("timeout_no_tx", tx_seen, 0);
    run_frame(tbl[0]);

    // Backpressure: reply held stable while a SYNC arrives and is dropped
    clear_mon();
    for (int i = 0; i < tbl[0].n; i++) send_byte(byte_at(tbl[0], i), 0);
    wait_tx();
    for (int k = 0; k < 50; k++) begin
      if (k == 10) send_byte(8'hA5, 0);
      else idle(1);
      chk("bp_hold", {bus.tx_valid, bus.tx_data}, {1'b1, 8'h06});
    end
    bus.tx_ready = 1'b1;
    idle(1);
    bus.tx_ready = 1'b0;
    chk("bp_drop", bus.tx_valid, 0);
    check_result(tbl[0]);
    clear_mon();
    for (int i = 1; i < tbl[0].n; i++) send_byte(byte_at(tbl[0], i), 0);
    idle(5);
    chk("bp_sync_dropped", {tx_seen, 8'(wr_addr.size())}, 0);

    // Reset in the middle of the payload
    clear_mon();
    for (int i = 0; i < 5; i++) send_byte(byte_at(tbl[0], i), 0);
    rst_n = 1'b0;
    idle(1);
    chk("midframe_reset",
        {bus.mem_we, bus.load_valid, bus.tx_valid, bus.mem_addr, bus.mem_data,
         bus.rows, bus.cols, bus.clue_len, bus.tx_data, bus.err_count}, 0);
    rst_n = 1'b1;
    exp_err = 0; exp_rows = 0; exp_cols = 0; exp_len = 0;
    tx_seen = 1'b0;
    send_byte(8'h22, 0);
    send_byte(8'h3C, 0);
    idle(5);
    chk("reset_no_reply", tx_seen, 0);
    run_frame(tbl[3]);

    // Random frames with leading noise and inter-byte gaps
    rnd_gaps = 1'b1;
    for (int r = 0; r < 60; r++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g, $urandom_range(0, 2));
      end
      v = rand_frame();
      run_frame(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
